mem_access_sequencer: RTL

- Multi-cycle data-memory access controller between the MEM stage and a byte-wide data-memory bus.
- Takes the decoded MemRead/MemWrite size codes, address and store data, and runs 1, 2 or 4 big-endian byte beats over a req/ack handshake.
- Assembles and sign-extends load data, and holds the pipeline stalled via busy until the access completes.

---
 rtl/mem_access_sequencer.sv | 259 +++++++++++++++++++++++++
 1 files changed

// File: rtl/mem_access_sequencer.sv
// mem_access_sequencer
// Multi-cycle data-memory access controller between the MEM stage and a
// byte-wide data-memory bus. Runs 1, 2 or 4 big-endian byte beats over a
// req/ack handshake, assembles and sign-extends load data, and holds busy
// high until the access completes.
//
// Optional feature macro: BUS_TIMEOUT_EN
//   defined   : each beat aborts with bus_err after TIMEOUT_CYCLES ack-less cycles
//   undefined : beats wait for ack indefinitely and bus_err is tied low
module mem_access_sequencer #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [2:0]  mem_read,
    input  logic [1:0]  mem_write,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] rdata,
    output logic        align_err,
    output logic        bus_err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [7:0]  bus_wdata,
    input  logic        bus_ack,
    input  logic [7:0]  bus_rdata
);

    // Size encoding shared by loads and stores: 0 none, 1 byte, 2 half, 3 word.
    localparam logic [1:0] SZ_NONE = 2'd0;
    localparam logic [1:0] SZ_BYTE = 2'd1;
    localparam logic [1:0] SZ_HALF = 2'd2;
    localparam logic [1:0] SZ_WORD = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        DONE = 2'd2
    } state_t;

    // The wait counter is 8 bits wide, so the limit must fit in it.
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be in 1..255");
    end

    state_t      state;
    logic [31:0] base_addr;
    logic [31:0] store_data;
    logic [1:0]  size;
    logic        is_store;
    logic [1:0]  beat_idx;
    logic [31:0] assembly;
`ifdef BUS_TIMEOUT_EN
    logic [7:0]  wait_cnt;
`endif

    // Number of beats for a size code.
    function automatic logic [2:0] beat_count(input logic [1:0] sz);
        case (sz)
            SZ_BYTE: beat_count = 3'd1;
            SZ_HALF: beat_count = 3'd2;
            SZ_WORD: beat_count = 3'd4;
            default: beat_count = 3'd0;
        endcase
    endfunction

    // Byte lane of beat k within the access: beat 0 is the most significant
    // byte of the access, so the lane counts down from n-1.
    function automatic logic [1:0] lane_of(input logic [1:0] sz, input logic [1:0] k);
        logic [2:0] n;
        n       = beat_count(sz);
        lane_of = 2'(n - 3'd1 - {1'b0, k});
    endfunction

    // Store byte sent on beat k.
    function automatic logic [7:0] store_byte(input logic [31:0] data,
                                              input logic [1:0]  sz,
                                              input logic [1:0]  k);
        logic [1:0] lane;
        lane       = lane_of(sz, k);
        store_byte = data[8*lane +: 8];
    endfunction

    // Assembly register with the byte returned on beat k written into its lane.
    function automatic logic [31:0] insert_byte(input logic [31:0] asm_in,
                                                input logic [7:0]  b,
                                                input logic [1:0]  sz,
                                                input logic [1:0]  k);
        logic [1:0]  lane;
        logic [31:0] tmp;
        lane = lane_of(sz, k);
        tmp  = asm_in;
        tmp[8*lane +: 8] = b;
        insert_byte = tmp;
    endfunction

    // Final load value: words pass through, sub-words are sign-extended.
    function automatic logic [31:0] extend_load(input logic [31:0] asm_in,
                                                input logic [1:0]  sz);
        case (sz)
            SZ_HALF: extend_load = {{16{asm_in[15]}}, asm_in[15:0]};
            SZ_BYTE: extend_load = {{24{asm_in[7]}}, asm_in[7:0]};
            default: extend_load = asm_in;
        endcase
    endfunction

    // Request decode straight off the MEM-stage inputs.
    logic [1:0] load_size;
    logic [1:0] req_size;
    logic       req_store;
    logic       req_illegal;
    logic       req_misaligned;

    // Decode the load code, pick the size and classify the request.
    always_comb begin
        case (mem_read)
            3'b110:  load_size = SZ_WORD;
            3'b010:  load_size = SZ_HALF;
            3'b100:  load_size = SZ_BYTE;
            default: load_size = SZ_NONE;
        endcase
        req_store      = (mem_write != 2'b00);
        req_size       = req_store ? mem_write : load_size;
        req_illegal    = req_store && (load_size != SZ_NONE);
        req_misaligned = ((req_size == SZ_HALF) && addr[0]) ||
                         ((req_size == SZ_WORD) && (addr[1:0] != 2'b00));
    end

    // Beat bookkeeping for the access in flight.
    logic [1:0]  next_idx;
    logic        last_beat;
    logic [31:0] asm_next;

    // Next beat index, last-beat detect and assembly with the acked byte.
    always_comb begin
        next_idx  = beat_idx + 2'd1;
        last_beat = (({1'b0, beat_idx} + 3'd1) == beat_count(size));
        asm_next  = insert_byte(assembly, bus_rdata, size, beat_idx);
    end

    // Sequencer FSM with all outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            base_addr  <= 32'd0;
            store_data <= 32'd0;
            size       <= SZ_NONE;
            is_store   <= 1'b0;
            beat_idx   <= 2'd0;
            assembly   <= 32'd0;
            busy       <= 1'b0;
            done       <= 1'b0;
            rdata      <= 32'd0;
            align_err  <= 1'b0;
            bus_req    <= 1'b0;
            bus_we     <= 1'b0;
            bus_addr   <= 32'd0;
            bus_wdata  <= 8'd0;
`ifdef BUS_TIMEOUT_EN
            bus_err    <= 1'b0;
            wait_cnt   <= 8'd0;
`endif
        end else begin
            done      <= 1'b0;
            align_err <= 1'b0;
`ifdef BUS_TIMEOUT_EN
            bus_err   <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (start) begin
                        base_addr  <= addr;
                        store_data <= wdata;
                        size       <= req_size;
                        is_store   <= req_store;
                        beat_idx   <= 2'd0;
                        assembly   <= 32'd0;
                        busy       <= 1'b1;
`ifdef BUS_TIMEOUT_EN
                        wait_cnt   <= 8'd0;
`endif
                        if (req_illegal || req_misaligned) begin
                            state     <= DONE;
                            done      <= 1'b1;
                            align_err <= 1'b1;
                        end else if (req_size == SZ_NONE) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state     <= XFER;
                            bus_req   <= 1'b1;
                            bus_we    <= req_store;
                            bus_addr  <= addr;
                            bus_wdata <= store_byte(wdata, req_size, 2'd0);
                        end
                    end
                end

                XFER: begin
                    if (bus_ack) begin
                        assembly <= asm_next;
`ifdef BUS_TIMEOUT_EN
                        wait_cnt <= 8'd0;
`endif
                        if (last_beat) begin
                            state     <= DONE;
                            done      <= 1'b1;
                            bus_req   <= 1'b0;
                            bus_we    <= 1'b0;
                            bus_addr  <= 32'd0;
                            bus_wdata <= 8'd0;
                            if (!is_store) begin
                                rdata <= extend_load(asm_next, size);
                            end
                        end else begin
                            beat_idx  <= next_idx;
                            bus_addr  <= base_addr + 32'(next_idx);
                            bus_wdata <= store_byte(store_data, size, next_idx);
                        end
`ifdef BUS_TIMEOUT_EN
                    end else if (wait_cnt == 8'(TIMEOUT_CYCLES)) begin
                        // Abort: the access finishes without touching rdata.
                        state     <= DONE;
                        done      <= 1'b1;
                        bus_err   <= 1'b1;
                        bus_req   <= 1'b0;
                        bus_we    <= 1'b0;
                        bus_addr  <= 32'd0;
                        bus_wdata <= 8'd0;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
`endif
                    end
                end

                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end

                default: begin
                    state   <= IDLE;
                    busy    <= 1'b0;
                    bus_req <= 1'b0;
                    bus_we  <= 1'b0;
                end
            endcase
        end
    end

`ifndef BUS_TIMEOUT_EN
    assign bus_err = 1'b0;
`endif

endmodule
